state_action_resolver: RTL

Downstream stage of the state processor. Pops `{src_port, action}` entries from the state processor's result FIFO and pairs them in order with packet-ready requests from the header parser. Resolves each pair into a one-hot output-queue bitmap or a drop decision for the output-port lookup / packet buffer. Packets whose result never arrives within a timeout are dropped; the late results they leave behind are discarded so the pairing stays aligned.

---
 rtl/state_action_resolver.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/state_action_resolver.sv
// rtl/state_action_resolver.sv - pairs state-processor results with packet requests into queue decisions
//
// Pops {src_port, action} entries from the result FIFO and pairs them, in
// order, with packet-ready pulses from the header parser. Each pair becomes a
// one-hot-per-queue destination bitmap or a drop. A packet whose result does
// not show up within TIMEOUT idle cycles is dropped, and the late result it
// leaves behind is popped and thrown away so later pairings stay aligned.
//
// Ports:
//   clk                 - sole clock
//   reset               - asynchronous, active-low reset
//   result_fifo_dout    - {src_port, action}, valid the cycle after rd_en
//   result_fifo_empty   - result FIFO empty
//   result_fifo_rd_en   - pop request (combinational)
//   pkt_req             - one pulse per packet awaiting a decision
//   pkt_req_rdy         - low while the pending counter is saturated
//   decision_vld        - decision available, held until decision_rdy
//   decision_rdy        - consumer accepts the decision
//   decision_ports      - destination queue bitmap
//   decision_drop       - packet is to be discarded
//   timeout_count       - packets dropped by timeout
//   drop_count          - drop decisions handed over, timeouts included
//   late_discard_count  - late results discarded

`ifndef OPENFLOW_ENTRY_SRC_PORT_WIDTH
`define OPENFLOW_ENTRY_SRC_PORT_WIDTH 8
`endif
`ifndef OPENFLOW_ACTION_WIDTH
`define OPENFLOW_ACTION_WIDTH 32
`endif

module state_action_resolver #(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int SRC_PORT_WIDTH    = `OPENFLOW_ENTRY_SRC_PORT_WIDTH,
  parameter int ACTION_WIDTH      = `OPENFLOW_ACTION_WIDTH,
  parameter int FWD_BITMAP_LSB    = 0,
  parameter int FLOOD_BIT         = 16,
  parameter int PEND_WIDTH        = 4,
  parameter int TIMEOUT           = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [SRC_PORT_WIDTH+ACTION_WIDTH-1:0] result_fifo_dout,
  input  logic                                   result_fifo_empty,
  output logic                                   result_fifo_rd_en,
  input  logic                                   pkt_req,
  output logic                                   pkt_req_rdy,
  output logic                                   decision_vld,
  input  logic                                   decision_rdy,
  output logic [NUM_OUTPUT_QUEUES-1:0]           decision_ports,
  output logic                                   decision_drop,
  output logic [31:0]                            timeout_count,
  output logic [31:0]                            drop_count,
  output logic [31:0]                            late_discard_count
);

  localparam int TIMER_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [PEND_WIDTH-1:0] pending;
  logic [PEND_WIDTH-1:0] skip;
  logic [TIMER_W-1:0]    timer;

  logic take_timeout;
  logic timer_inc;
  logic discard;
  logic resolve;
  logic handshake;
  logic pend_inc;

  logic [SRC_PORT_WIDTH-1:0]    src_port;
  logic [ACTION_WIDTH-1:0]      action;
  logic [NUM_OUTPUT_QUEUES-1:0] res_ports;
  logic                         unused_action_bits;

  assign {src_port, action} = result_fifo_dout;
  // Only the bitmap and flood fields of the action are consumed here.
  assign unused_action_bits = ^action;

  assign pkt_req_rdy = (pending != '1);
  assign pend_inc    = pkt_req & pkt_req_rdy;
  assign handshake   = decision_vld & decision_rdy;
  assign discard     = (state == S_LATCH) && (skip != '0);
  assign resolve     = (state == S_LATCH) && (skip == '0);

  // Flood: every queue except the one the packet came in on. A source port
  // beyond the queue range matches no bit, so nothing is cleared.
  always_comb begin
    res_ports = action[FWD_BITMAP_LSB +: NUM_OUTPUT_QUEUES];
    if (action[FLOOD_BIT]) begin
      for (int i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
        res_ports[i] = (src_port != SRC_PORT_WIDTH'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A result that is ready always wins over an expiring timer; results owed
  // to timed-out packets are popped even with nothing pending.
  always_comb begin
    state_next        = state;
    result_fifo_rd_en = 1'b0;
    take_timeout      = 1'b0;
    timer_inc         = 1'b0;
    case (state)
      S_IDLE: begin
        if (!result_fifo_empty && ((pending != '0) || (skip != '0))) begin
          result_fifo_rd_en = 1'b1;
          state_next        = S_LATCH;
        end else if (pending != '0) begin
          if (timer == TIMER_W'(TIMEOUT - 1)) begin
            take_timeout = 1'b1;
            state_next   = S_OUT;
          end else begin
            timer_inc = 1'b1;
          end
        end
      end
      S_LATCH: begin
        state_next = (skip != '0) ? S_IDLE : S_OUT;
      end
      S_OUT: begin
        if (decision_rdy) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending            <= '0;
      skip               <= '0;
      timer              <= '0;
      timeout_count      <= '0;
      drop_count         <= '0;
      late_discard_count <= '0;
      decision_vld       <= 1'b0;
      decision_ports     <= '0;
      decision_drop      <= 1'b0;
    end else begin
      if (pend_inc && !handshake) begin
        pending <= pending + 1'b1;
      end else if (!pend_inc && handshake) begin
        pending <= pending - 1'b1;
      end

      if (take_timeout) begin
        if (skip != '1) begin
          skip <= skip + 1'b1;
        end
        timeout_count <= timeout_count + 32'd1;
      end else if (discard) begin
        skip               <= skip - 1'b1;
        late_discard_count <= late_discard_count + 32'd1;
      end

      // The timer only measures uninterrupted waiting in IDLE.
      if ((state != S_IDLE) || (state_next != S_IDLE) || (pending == '0)) begin
        timer <= '0;
      end else if (timer_inc) begin
        timer <= timer + 1'b1;
      end

      if (take_timeout) begin
        decision_vld   <= 1'b1;
        decision_ports <= '0;
        decision_drop  <= 1'b1;
      end else if (resolve) begin
        decision_vld   <= 1'b1;
        decision_ports <= res_ports;
        decision_drop  <= (res_ports == '0);
      end else if (handshake) begin
        decision_vld   <= 1'b0;
        decision_ports <= '0;
        decision_drop  <= 1'b0;
      end

      if (handshake && decision_drop) begin
        drop_count <= drop_count + 32'd1;
      end
    end
  end

endmodule
